rdreq_sel: RTL



---
 rtl/rdreq_sel.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rdreq_sel.sv
// Round-robin read-request selector: locks one user channel onto the DDR3 core
// read port for a whole burst and routes returned beats/finish back to it.
module rdreq_sel #(
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_ADDR_WIDTH = 28,
  parameter int CHANNEL_NUM    = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CHANNEL_NUM-1:0]             rd_req_,
  input  logic [APP_ADDR_WIDTH*CHANNEL_NUM-1:0] rd_addr_,
  input  logic [10*CHANNEL_NUM-1:0]          rd_num_,
  output logic [CHANNEL_NUM-1:0]             rd_grant_,
  output logic [CHANNEL_NUM-1:0]             rd_valid_,
  output logic [CHANNEL_NUM-1:0]             rd_finish_,
  output logic [APP_DATA_WIDTH-1:0]          rd_data_,
  output logic                               rd_err,
  output logic                               rd_req,
  output logic [APP_ADDR_WIDTH-1:0]          rd_addr,
  output logic [9:0]                         rd_num,
  input  logic                               rd_allow,
  input  logic [APP_DATA_WIDTH-1:0]          rd_data,
  input  logic                               rd_finish
);

  localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t                      r_state;
  logic [PTR_W-1:0]            r_ptr;
  logic [PTR_W-1:0]            r_sel_idx;
  logic [CHANNEL_NUM-1:0]      r_sel;
  logic [10:0]                 r_cnt;
  logic [CHANNEL_NUM-1:0]      r_grant;
  logic [CHANNEL_NUM-1:0]      r_valid;
  logic [CHANNEL_NUM-1:0]      r_finish;
  logic [APP_DATA_WIDTH-1:0]   r_data;
  logic                        r_err;
  logic                        r_req;
  logic [APP_ADDR_WIDTH-1:0]   r_addr;
  logic [9:0]                  r_num;

  logic                        w_any;
  logic [PTR_W-1:0]            w_win_idx;
  logic [CHANNEL_NUM-1:0]      w_win_oh;
  logic [APP_ADDR_WIDTH-1:0]   w_win_addr;
  logic [9:0]                  w_win_num;
  logic [10:0]                 w_cnt_nxt;

  // Beat counter never wraps, so an overlong burst can't alias to a good count.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Round-robin: scan upward from the channel after the last one served.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] v_idx;
    idx       = 0;
    v_idx     = '0;
    w_any     = 1'b0;
    w_win_idx = '0;
    w_win_oh  = '0;
    for (int k = 1; k <= CHANNEL_NUM; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= CHANNEL_NUM) idx = idx - CHANNEL_NUM;
      v_idx = PTR_W'(idx);
      if (!w_any && rd_req_[v_idx]) begin
        w_any     = 1'b1;
        w_win_idx = v_idx;
      end
    end
    if (w_any) w_win_oh[w_win_idx] = 1'b1;
  end

  assign w_win_addr = rd_addr_[w_win_idx*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
  assign w_win_num  = rd_num_[w_win_idx*10 +: 10];
  assign w_cnt_nxt  = rd_allow ? sat_inc(r_cnt) : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= PTR_W'(CHANNEL_NUM - 1);
      r_sel_idx <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_valid   <= '0;
      r_finish  <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_num     <= '0;
    end else begin
      r_valid  <= '0;
      r_finish <= '0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_addr    <= w_win_addr;
            r_num     <= w_win_num;
            r_sel     <= w_win_oh;
            r_sel_idx <= w_win_idx;
            r_cnt     <= '0;
            // Zero-length request never reaches the core; answer it locally.
            if (w_win_num == 10'd0) begin
              r_err    <= 1'b1;
              r_finish <= w_win_oh;
              r_ptr    <= w_win_idx;
              r_state  <= S_RELEASE;
            end else begin
              r_req   <= 1'b1;
              r_grant <= w_win_oh;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (rd_allow) begin
            r_data  <= rd_data;
            r_valid <= r_sel;
            r_cnt   <= w_cnt_nxt;
          end
          if (rd_finish) begin
            r_finish <= r_sel;
            r_req    <= 1'b0;
            r_grant  <= '0;
            r_ptr    <= r_sel_idx;
            r_err    <= (w_cnt_nxt != {1'b0, r_num});
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_grant_  = r_grant;
  assign rd_valid_  = r_valid;
  assign rd_finish_ = r_finish;
  assign rd_data_   = r_data;
  assign rd_err     = r_err;
  assign rd_req     = r_req;
  assign rd_addr    = r_addr;
  assign rd_num     = r_num;

endmodule
